// File: rtl/sd_spi_response_transmitter_if.sv
// Bus bundle for the SD SPI-mode response transmitter: raw SPI pins,
// the response request from the command side, and status back.
interface sd_spi_response_transmitter_if;
  logic        io_SCK;
  logic        io_CS;
  logic        io_Start;
  logic [1:0]  io_ResponseType;
  logic [7:0]  io_R1;
  logic [31:0] io_Payload;
  logic        io_CardBusy;
  logic        io_DO;
  logic        io_Busy;
  logic        io_Done;
  logic        io_Aborted;

  // Requesting side: drives the pins and the request, watches the status.
  modport master (
    output io_SCK, io_CS, io_Start, io_ResponseType, io_R1, io_Payload, io_CardBusy,
    input  io_DO, io_Busy, io_Done, io_Aborted
  );

  // Transmitter side.
  modport slave (
    input  io_SCK, io_CS, io_Start, io_ResponseType, io_R1, io_Payload, io_CardBusy,
    output io_DO, io_Busy, io_Done, io_Aborted
  );
endinterface

// File: rtl/sd_spi_response_transmitter.sv
// SD-card SPI-mode response transmitter (R1/R1b/R3/R7).
// Oversamples SCK/CS on the system clock and shifts the framed response
// out MSB first, changing DO after each SCK fall (SPI mode 0).
// Optional macro SD_SPI_R1B_BUSY_EN: after an R1b status byte, keep sending
// 0x00 busy tokens while io_CardBusy is high at each byte boundary.
//
// state   | meaning
// IDLE    | DO=1, waiting for io_Start
// SHIFT   | shifting NCR filler + R1 (+ payload) on SCK falls
// BUSYTOK | R1b busy tokens (macro builds only)
// DONE    | one-cycle completion pulse
module sd_spi_response_transmitter #(
  parameter int NCR_BYTES   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic                         clock,
  input logic                         reset,
  sd_spi_response_transmitter_if.slave bus
);

  localparam int         SR_W       = 8 * NCR_BYTES + 40;
  localparam logic [6:0] BITS_SHORT = 7'(8 * NCR_BYTES + 8);
  localparam logic [6:0] BITS_LONG  = 7'(8 * NCR_BYTES + 40);

`ifdef SD_SPI_R1B_BUSY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, BUSYTOK, DONE} state_t;
  localparam logic [SR_W-1:0] TOKEN_LOAD = {8'h00, {(SR_W-8){1'b1}}};
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t                 state_q;
  logic [SR_W-1:0]        shift_q;
  logic [6:0]             cnt_q;
  logic [6:0]             bits_total_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   aborted_q;
`ifdef SD_SPI_R1B_BUSY_EN
  logic                   is_r1b_q;
  logic [2:0]             tok_cnt_q;
`endif

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, fall, cs_rise, long_rsp;
  logic [SR_W-1:0]        shift_fill_d, load_d;
  logic [6:0]             cnt_d;

  assign sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], bus.io_SCK};
  assign cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], bus.io_CS};
  assign sck_s        = sck_sync_q[SYNC_STAGES-1];
  assign cs_s         = cs_sync_q[SYNC_STAGES-1];
  // Falls only count while the card is selected; a CS release wins over a fall.
  assign fall         = sck_prev_q & ~sck_s & ~cs_s;
  assign cs_rise      = ~cs_prev_q & cs_s;
  assign shift_fill_d = {shift_q[SR_W-2:0], 1'b1};
  assign cnt_d        = cnt_q + 7'd1;
  assign long_rsp     = (bus.io_ResponseType == 2'd2) || (bus.io_ResponseType == 2'd3);
  // Left-aligned frame; short responses leave trailing ones so DO idles high.
  assign load_d       = {{NCR_BYTES{8'hFF}}, bus.io_R1,
                         long_rsp ? bus.io_Payload : 32'hFFFF_FFFF};

  assign bus.io_DO      = shift_q[SR_W-1];
  assign bus.io_Busy    = busy_q;
  assign bus.io_Done    = done_q;
  assign bus.io_Aborted = aborted_q;

  // Synchronise the raw SPI pins and keep their previous synced values for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= sck_sync_d;
      cs_sync_q  <= cs_sync_d;
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  // Response framing FSM with registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '1;
      cnt_q        <= '0;
      bits_total_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
`ifdef SD_SPI_R1B_BUSY_EN
      is_r1b_q     <= 1'b0;
      tok_cnt_q    <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.io_Start) begin
            shift_q      <= load_d;
            bits_total_q <= long_rsp ? BITS_LONG : BITS_SHORT;
            cnt_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= SHIFT;
`ifdef SD_SPI_R1B_BUSY_EN
            is_r1b_q     <= (bus.io_ResponseType == 2'd1);
`endif
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            shift_q   <= '1;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else if (fall) begin
            shift_q <= shift_fill_d;
            cnt_q   <= cnt_d;
            if (cnt_d == bits_total_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
`ifdef SD_SPI_R1B_BUSY_EN
              // First busy boundary is the fall that completes the R1 byte.
              if (is_r1b_q && bus.io_CardBusy) begin
                state_q   <= BUSYTOK;
                done_q    <= 1'b0;
                busy_q    <= 1'b1;
                shift_q   <= TOKEN_LOAD;
                tok_cnt_q <= '0;
              end
`endif
            end
          end
        end
`ifdef SD_SPI_R1B_BUSY_EN
        BUSYTOK: begin
          if (cs_rise) begin
            shift_q   <= '1;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
            state_q   <= IDLE;
          end else if (fall) begin
            shift_q   <= shift_fill_d;
            tok_cnt_q <= tok_cnt_q + 3'd1;
            if (tok_cnt_q == 3'd7) begin
              if (bus.io_CardBusy) begin
                shift_q <= TOKEN_LOAD;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          shift_q <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_spi_response_transmitter.md
Name: sd_spi_response_transmitter

Overview:
- SD-card SPI-mode slave transmitter: serialises the card's command response (R1, R1b, R3, R7) onto the MISO/DO line back to the host.
- Counterpart of the command receiver. The receiver's decoded command drives response selection upstream; this block only frames and shifts the bytes.
- Runs on the fast system clock and oversamples SCK/CS, matching the receiver side.
- SPI mode 0: the host samples on SCK rise, and this block changes DO after each SCK fall.

Parameters:
- NCR_BYTES, 1, number of 0xFF filler bytes before the R1 byte (legal 1..8).
- SYNC_STAGES, 2, synchroniser depth for io_SCK and io_CS (legal 2..3).

Ports:
- clock  input  1  system clock; must be at least 8x the SCK frequency.
- reset  input  1  asynchronous, active-low reset.
- io_SCK  input  1  raw SPI clock from the host.
- io_CS  input  1  raw chip select, active low.
- io_Start  input  1  one-cycle request to send a response.
- io_ResponseType  input  2  0=R1, 1=R1b, 2=R3, 3=R7.
- io_R1  input  8  R1 status byte.
- io_Payload  input  32  trailing 32 bits for R3/R7, MSB first; ignored for R1/R1b.
- io_CardBusy  input  1  card busy level, used for R1b only.
- io_DO  output  1  serial data to the host.
- io_Busy  output  1  high while a response is in progress.
- io_Done  output  1  one-cycle pulse on normal completion.
- io_Aborted  output  1  one-cycle pulse when CS deasserts mid-response.

Behaviour:
- Reset values: io_DO=1, io_Busy=0, io_Done=0, io_Aborted=0, state=IDLE, shift register all ones, bit counter 0. An async reset mid-operation immediately returns to these values.
- Synchronisation: io_SCK and io_CS each pass through SYNC_STAGES flops. A falling edge (fall) = previous synced SCK 1 and current synced SCK 0. A fall counts only while synced CS=0.
- DO always equals shift register bit MSB.
- States: IDLE, SHIFT, BUSYTOK, DONE.
- IDLE:
  - io_DO=1.
  - io_Start=1 captures the inputs. The shift register loads {NCR_BYTES x 0xFF, io_R1, io_Payload if type R3/R7}.
  - bits_total = 8*NCR_BYTES + 8 for R1/R1b, or + 40 for R3/R7. The bit counter is cleared.
  - io_Busy goes high the next cycle, and the state moves to SHIFT.
  - Inputs are not referenced after capture.
- SHIFT:
  - Each fall shifts left with 1 fill and increments the counter.
  - When the counter reaches bits_total, go to DONE.
  - Exception: type R1b goes to BUSYTOK when the macro is enabled.
- DONE (one cycle): io_Done=1, io_Busy=0, io_DO=1, return to IDLE.
- io_Start while io_Busy=1 is ignored, with no effect on the response in flight.
- io_Start while CS is high is accepted; shifting waits for CS low.
- CS deasserts (synced 0 to 1) in SHIFT/BUSYTOK:
  - Abort: pulse io_Aborted for one cycle, io_DO=1, io_Busy=0, shift register all ones, state IDLE.
  - No io_Done.
  - Abort and a coincident fall in the same cycle resolve as abort.
- DO latency: DO changes SYNC_STAGES+1 clock cycles after the raw SCK fall. This is well inside a half SCK period at the 8x ratio.
- Width rule: the counter is 7 bits (max 104 bits).

Optional Feature:
- Macro: SD_SPI_R1B_BUSY_EN.
- Enabled, BUSYTOK state after the R1 byte of an R1b response:
  - At each byte boundary (entry, then every 8 falls), sample io_CardBusy.
  - If high, load 0x00 and send 8 zero bits.
  - If low, go to DONE.
  - CS abort applies as in SHIFT.
- Disabled: BUSYTOK is absent and R1b is sent exactly as R1. io_CardBusy is unused.

Test Plan:
- After reset, hold 5 cycles -> io_DO=1, io_Busy=0, io_Done=0, io_Aborted=0. Toggle SCK with CS low -> io_DO stays 1.
- Start type R1, io_R1=0x01, NCR_BYTES=1, CS low, 16 SCK clocks -> DO at each SCK rise = 0xFF then 0x01. io_Done pulses once, about SYNC_STAGES+2 cycles after the 16th fall. io_DO=1 afterward.
- Start type R7, io_R1=0x01, io_Payload=0x000001AA, 48 SCK clocks -> bytes FF 01 00 00 01 AA. Change io_Payload to 0xFFFFFFFF one cycle after Start -> output unchanged.
- Start type R3, io_R1=0x00, io_Payload=0x40FF8000. Pulse io_Start again at SCK clock 12 -> bytes FF 00 40 FF 80 00, and only one io_Done.
- Start type R7. Raise CS after 10 falls -> io_Aborted one pulse, no io_Done, DO=1, io_Busy=0. A following R1 request with 0x05 -> FF 05 correctly.
- Start type R1b, io_R1=0x00, io_CardBusy high for the first two byte boundaries then low:
  - Macro on -> FF 00 00 00 then io_Done.
  - Macro off -> FF 00 then io_Done.
